// File: rtl/tx_pattern_gen_if.sv
// Control and pattern-output bundle for tx_pattern_gen.
// The master drives configuration and injection requests; the slave returns the word stream.
interface tx_pattern_gen_if;
  logic        cke;
  logic        load;
  logic [1:0]  mode;
  logic [1:0]  prbs_sel;
  logic [15:0] user_word;
  logic        inj_err;
  logic [15:0] dout;
  logic        valid;
  logic [7:0]  err_cnt;

  modport master (
    output cke, load, mode, prbs_sel, user_word, inj_err,
    input  dout, valid, err_cnt
  );

  modport slave (
    input  cke, load, mode, prbs_sel, user_word, inj_err,
    output dout, valid, err_cnt
  );
endinterface

// File: rtl/tx_pattern_gen.sv
// 16-bit parallel test-pattern generator (PRBS7/15/31, user word, clock, zero) feeding a 16:4 mux.
// A single-bit error can be injected into bit 0 of one output word via an asynchronous request.
module tx_pattern_gen (
  input  logic               clk,
  input  logic               rst,
  tx_pattern_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  mode_r;
  logic [1:0]  prbs_sel_r;
  logic [15:0] user_word_r;
  logic [30:0] lfsr_r;
  logic [1:0]  sync_r;
  logic        sync_prev_r;
  logic [15:0] dout_r;
  logic        valid_r;
  logic [7:0]  err_cnt_r;

  logic        edge_s;
  logic        run_hold_s;
  logic        inject_s;
  logic        enter_seed_s;
  logic [46:0] step_s;
  logic [15:0] word_s;

  // Advance the Fibonacci LFSR 16 serial steps; first generated bit lands in word[15].
  function automatic logic [46:0] prbs_step16(input logic [30:0] seed, input logic [1:0] sel);
    logic [30:0] s;
    logic [15:0] w;
    logic        fb;
    s = seed;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case (sel)
        2'd1:    fb = s[14] ^ s[13];
        2'd2:    fb = s[30] ^ s[27];
        default: fb = s[6] ^ s[5];
      endcase
      s = {s[29:0], fb};
      w[15 - i] = fb;
    end
    return {s, w};
  endfunction

  assign edge_s       = sync_r[1] & ~sync_prev_r;
  assign run_hold_s   = (state_r == RUN) && (state_s == RUN);
  assign inject_s     = run_hold_s & edge_s;
  assign enter_seed_s = (state_s == SEED) && (state_r != SEED);
  assign step_s       = prbs_step16(lfsr_r, prbs_sel_r);

  // Next-state logic; SEED always moves on to RUN so a load there is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          state_s = SEED;
        end else begin
          state_s = IDLE;
        end
      end
      SEED: state_s = RUN;
      RUN: begin
        if (bus.load) begin
          state_s = SEED;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Pattern word selected by the shadowed mode.
  always_comb begin
    word_s = 16'h0000;
    case (mode_r)
      2'd0:    word_s = step_s[15:0];
      2'd1:    word_s = user_word_r;
      2'd2:    word_s = 16'hAAAA;
      2'd3:    word_s = 16'h0000;
      default: word_s = 16'h0000;
    endcase
  end

  // All state, gated by cke; outputs are produced only while RUN persists across the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mode_r      <= 2'd0;
      prbs_sel_r  <= 2'd0;
      user_word_r <= 16'h0000;
      lfsr_r      <= {31{1'b1}};
      sync_r      <= 2'b00;
      sync_prev_r <= 1'b0;
      dout_r      <= 16'h0000;
      valid_r     <= 1'b0;
      err_cnt_r   <= 8'h00;
    end else if (bus.cke) begin
      state_r     <= state_s;
      sync_r      <= {sync_r[0], bus.inj_err};
      sync_prev_r <= sync_r[1];
      if (enter_seed_s) begin
        mode_r      <= bus.mode;
        prbs_sel_r  <= bus.prbs_sel;
        user_word_r <= bus.user_word;
      end
      if (state_r == SEED) begin
        lfsr_r <= {31{1'b1}};
      end else if (run_hold_s && (mode_r == 2'd0)) begin
        lfsr_r <= step_s[46:16];
      end
      // Injection flips only the outgoing word; the LFSR keeps its true sequence.
      if (run_hold_s) begin
        dout_r  <= word_s ^ {15'd0, inject_s};
        valid_r <= 1'b1;
      end else begin
        dout_r  <= 16'h0000;
        valid_r <= 1'b0;
      end
      if (inject_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign bus.dout    = dout_r;
  assign bus.valid   = valid_r;
  assign bus.err_cnt = err_cnt_r;

endmodule

// File: doc/tx_pattern_gen.md
TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: word clock, same clock that drives the 16-to-4 mux clk_prbs input; all state is updated on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port cke, input, 1 bit: clock enable; when low, all state holds.
REQ-004 SHALL have port load, input, 1 bit: single-cycle request to latch the configuration and reseed.
REQ-005 SHALL have port mode, input, 2 bits: 0 = PRBS, 1 = user word, 2 = clock pattern, 3 = all-zero.
REQ-006 SHALL have port prbs_sel, input, 2 bits: 0 = PRBS7, 1 = PRBS15, 2 = PRBS31, 3 = PRBS7.
REQ-007 SHALL have port user_word, input, 16 bits: fixed pattern used in mode 1.
REQ-008 SHALL have port inj_err, input, 1 bit: error-injection request; level input, edge-detected internally.
REQ-009 SHALL have port dout, output, 16 bits: parallel word to the 16-to-4 mux; dout[15] is the first bit in time.
REQ-010 SHALL have port valid, output, 1 bit: high while dout carries pattern data.
REQ-011 SHALL have port err_cnt, output, 8 bits: count of injected errors.

Function
REQ-012 SHALL implement an FSM with states IDLE, SEED and RUN; all transitions SHALL qualify on cke=1.
REQ-013 IDLE -> SEED on load=1; SEED -> RUN unconditionally after one cycle; RUN -> SEED on load=1; no other transitions.
REQ-014 On entry to SEED, SHALL register mode, prbs_sel and user_word into shadow registers; changes on these inputs outside a load SHALL have no effect.
REQ-015 SEED SHALL load the 31-bit LFSR with all ones and drive dout=16'h0000, valid=0.
REQ-016 For load sampled at edge N, the first valid word SHALL appear after edge N+2, and valid SHALL stay high in RUN.
REQ-017 The LFSR SHALL be a Fibonacci LFSR with these polynomials:
- PRBS7: x^7+x^6+1
- PRBS15: x^15+x^14+1
- PRBS31: x^31+x^28+1
Only the low 7, 15 or 31 bits SHALL be used for the selected length.
REQ-018 In RUN with mode 0, the LFSR SHALL advance exactly 16 serial steps per enabled cycle; the 16 output bits SHALL map oldest to dout[15] and newest to dout[0].
REQ-019 In RUN, mode 1 SHALL output the shadowed user_word, mode 2 SHALL output 16'hAAAA, and mode 3 SHALL output 16'h0000; the LFSR SHALL hold in modes 1-3.
REQ-020 dout and valid SHALL be registered outputs with no combinational path from any input.
REQ-021 inj_err SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-022 Each detected edge while in RUN SHALL invert dout[0] of exactly the next output word only; the LFSR sequence SHALL be unaffected.
REQ-023 Each applied injection SHALL increment err_cnt by 1, saturating at 8'hFF.
REQ-024 An edge detected outside RUN SHALL be discarded and SHALL not be counted.
REQ-025 A load and an injection edge in the same cycle: load SHALL win, and the injection SHALL be discarded.
REQ-026 A load while in SEED SHALL be ignored.
REQ-027 err_cnt SHALL clear only on rst; load SHALL not clear it.
REQ-028 When cke=0, dout, valid, the FSM, the LFSR, the synchronizer and err_cnt SHALL all hold.

Reset
REQ-029 rst=1 SHALL immediately, with no clock required, force the following values:
- FSM = IDLE, dout = 16'h0000, valid = 0, err_cnt = 8'h00
- LFSR = all ones, synchronizer = 0
- shadow registers: mode = 0, prbs_sel = 0, user_word = 16'h0000
REQ-030 Asserting rst mid-RUN SHALL abort the pattern.
REQ-031 After rst deasserts, the block SHALL remain in IDLE until load.

Verification
REQ-032 Bench SHALL check: reset, then load with mode=1, user_word=16'h1234 -> valid=0 for 2 edges, then dout=16'h1234 every cycle.
REQ-033 Bench SHALL check: load with mode=0, prbs_sel=0 -> serialized dout[15..0] matches the bit-accurate PRBS7 model from all-ones seed; word k equals word k+127; no all-zero 7-bit run.
REQ-034 Bench SHALL check: PRBS31 running, one inj_err pulse -> exactly one word differs from the model, only in bit 0, 3-4 cycles after the pulse; err_cnt=1.
REQ-035 Bench SHALL check: 300 injection pulses in RUN -> err_cnt=8'hFF and holds.
REQ-036 Bench SHALL check: load asserted in the same cycle as an inj_err edge -> no inversion, err_cnt unchanged, reseed proceeds.
REQ-037 Bench SHALL check: rst pulse mid-RUN with cke toggling -> outputs go to zero immediately, IDLE persists until load; with cke=0 held for 10 cycles, dout is frozen.
